// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle ARM-subset controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } statetype_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/decodificador_alu.sv
// rtl/decodificador_alu.sv - maps (ALUOp, cmd, S) to ALUControl, FlagW and NoWrite
module decodificador_alu
  import ctrl_pkg::*;
(
  input  logic       alu_op,
  input  logic [3:0] cmd,
  input  logic       s_bit,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic [1:0] cmd_ctl;
  logic       cmd_arith;
  logic       cmd_valid;

  // NoWrite is taken from cmd alone so the writeback state can use it with ALUOp=0
  always_comb begin
    cmd_ctl   = ALU_ADD;
    cmd_arith = 1'b0;
    cmd_valid = 1'b1;
    no_write  = 1'b0;
    unique case (cmd)
      CMD_ADD: begin
        cmd_ctl   = ALU_ADD;
        cmd_arith = 1'b1;
      end
      CMD_SUB: begin
        cmd_ctl   = ALU_SUB;
        cmd_arith = 1'b1;
      end
      CMD_AND: cmd_ctl = ALU_AND;
      CMD_ORR: cmd_ctl = ALU_ORR;
      CMD_CMP: begin
        cmd_ctl   = ALU_SUB;
        cmd_arith = 1'b1;
        no_write  = 1'b1;
      end
      default: begin
        cmd_ctl   = ALU_ADD;
        cmd_valid = 1'b0;
        no_write  = 1'b1;
      end
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      alu_control = cmd_ctl;
      if (cmd_valid) begin
        flag_w = {s_bit, s_bit & cmd_arith};
      end
    end
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - multicycle main controller (Moore FSM + decode)
module unidad_control_multiciclo
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW
);

  statetype_t state_q, state_d;

  logic       next_pc_r;
  logic       ir_write_r;
  logic       reg_w_r;
  logic       mem_w_r;
  logic       branch_r;
  logic       alu_op_r;
  logic [1:0] flag_w_dec;
  logic       no_write;

  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        unique case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    next_pc_r  = 1'b0;
    ir_write_r = 1'b0;
    reg_w_r    = 1'b0;
    mem_w_r    = 1'b0;
    branch_r   = 1'b0;
    alu_op_r   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    unique case (state_q)
      FETCH: begin
        ir_write_r = 1'b1;
        next_pc_r  = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR:   ALUSrcB = SRCB_IMM;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w_r   = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc  = 1'b1;
        mem_w_r = 1'b1;
      end
      EXECUTER: alu_op_r = 1'b1;
      EXECUTEI: begin
        ALUSrcB  = SRCB_IMM;
        alu_op_r = 1'b1;
      end
      ALUWB:    reg_w_r = ~no_write;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch_r  = 1'b1;
      end
      default: ;
    endcase
  end

  decodificador_alu u_alu (
    .alu_op      (alu_op_r),
    .cmd         (Funct[4:1]),
    .s_bit       (Funct[0]),
    .alu_control (ALUControl),
    .flag_w      (flag_w_dec),
    .no_write    (no_write)
  );

  // State already sits in FETCH during reset; only the write/enable requests need masking
  assign NextPC  = reset & next_pc_r;
  assign IRWrite = reset & ir_write_r;
  assign RegW    = reset & reg_w_r;
  assign MemW    = reset & mem_w_r;
  assign FlagW   = reset ? flag_w_dec : 2'b00;
  assign PCS     = reset & ((reg_w_r & (Rd == REG_PC)) | branch_r);

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb/tb_unidad_control_multiciclo.sv - bench for unidad_control_multiciclo
module tb_unidad_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       NextPC, IRWrite, AdrSrc, ALUSrcA, PCS, RegW, MemW;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc, FlagW;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unidad_control_multiciclo dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .NextPC     (NextPC),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW)
  );

  typedef struct packed {
    logic       next_pc;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
  } outs_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         lat;
    logic [1:0] fw;
    int         pcs_n;
    int         regw_n;
    int         memw_n;
    string      name;
  } vec_t;

  vec_t vq[$];

  function automatic outs_t cur();
    outs_t o;
    o.next_pc = NextPC;        o.ir_write = IRWrite;      o.adr_src = AdrSrc;
    o.result_src = ResultSrc;  o.alu_src_a = ALUSrcA;     o.alu_src_b = ALUSrcB;
    o.alu_control = ALUControl; o.imm_src = ImmSrc;       o.reg_src = RegSrc;
    o.flag_w = FlagW;          o.pcs = PCS;               o.reg_w = RegW;
    o.mem_w = MemW;
    return o;
  endfunction

  // ALU command table: {ALUControl, FlagW, NoWrite}
  function automatic logic [4:0] alu_ref(input logic [3:0] cmd, input logic s);
    case (cmd)
      4'd4:    return {2'b00, s, s, 1'b0};
      4'd2:    return {2'b01, s, s, 1'b0};
      4'd0:    return {2'b10, s, 1'b0, 1'b0};
      4'd12:   return {2'b11, s, 1'b0, 1'b0};
      4'd10:   return {2'b01, s, s, 1'b1};
      default: return {2'b00, 2'b00, 1'b1};
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [5:0] funct);
    case (op)
      2'b00:   return 4;
      2'b01:   return funct[0] ? 5 : 4;
      default: return 3;
    endcase
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is the fetch cycle)
  function automatic outs_t model(input logic [1:0] op, input logic [5:0] funct,
                                  input logic [3:0] rd, input int k);
    outs_t o;
    logic [4:0] a;
    o = '0;
    a = alu_ref(funct[4:1], funct[0]);
    o.imm_src = op;
    o.reg_src = {op == 2'b01, op == 2'b10};
    if (k == 0) begin
      o.next_pc = 1; o.ir_write = 1; o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2;
    end else if (k == 1) begin
      o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2;
    end else if (op == 2'b00) begin
      if (k == 2) begin
        o.alu_src_b = funct[5] ? 2'd1 : 2'd0;
        o.alu_control = a[4:3];
        o.flag_w = a[2:1];
      end else begin
        o.reg_w = !a[0];
        o.pcs = !a[0] && rd == 4'd15;
      end
    end else if (op == 2'b01) begin
      if (k == 2) o.alu_src_b = 1;
      else if (k == 3) begin
        o.adr_src = 1;
        o.mem_w = !funct[0];
      end else begin
        o.result_src = 1; o.reg_w = 1; o.pcs = rd == 4'd15;
      end
    end else if (op == 2'b10) begin
      o.alu_src_b = 1; o.result_src = 2; o.pcs = 1;
    end
    return o;
  endfunction

  task automatic check_outs(input string name, input outs_t exp);
    outs_t act;
    act = cur();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts at a negedge in FETCH, ends at the negedge of the next FETCH
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input string name, output int lat, output logic [1:0] fw2,
                           output int pcs_n, output int regw_n, output int memw_n);
    int  k;
    bit  done;
    Op = op; Funct = funct; Rd = rd;
    #1;
    k = 0; done = 0; pcs_n = 0; regw_n = 0; memw_n = 0; fw2 = 2'b00;
    check_outs($sformatf("%s c0", name), model(op, funct, rd, 0));
    while (!done && k < 10) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (NextPC) done = 1;
      else begin
        check_outs($sformatf("%s c%0d", name, k), model(op, funct, rd, k));
        pcs_n += int'(PCS); regw_n += int'(RegW); memw_n += int'(MemW);
        if (k == 2) fw2 = FlagW;
      end
    end
    if (!done) check_int({name, " timeout"}, k, -1);
    lat = k;
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                              input int lat, input logic [1:0] fw, input int p, input int r,
                              input int m, input string name);
    vec_t v;
    v.op = op; v.funct = funct; v.rd = rd; v.lat = lat; v.fw = fw;
    v.pcs_n = p; v.regw_n = r; v.memw_n = m; v.name = name;
    return v;
  endfunction

  initial begin
    int lat, p, r, m;
    logic [1:0] fw;
    outs_t rexp;

    vq.push_back(mk(2'b00, 6'b001000, 4'd1,  4, 2'b00, 0, 1, 0, "add_r1"));
    vq.push_back(mk(2'b00, 6'b100101, 4'd0,  4, 2'b11, 0, 1, 0, "subs_imm"));
    vq.push_back(mk(2'b00, 6'b010101, 4'd0,  4, 2'b11, 0, 0, 0, "cmp"));
    vq.push_back(mk(2'b01, 6'b000001, 4'd2,  5, 2'b00, 0, 1, 0, "ldr"));
    vq.push_back(mk(2'b01, 6'b000000, 4'd3,  4, 2'b00, 0, 0, 1, "str"));
    vq.push_back(mk(2'b10, 6'b000000, 4'd0,  3, 2'b00, 1, 0, 0, "b"));
    vq.push_back(mk(2'b00, 6'b001000, 4'd15, 4, 2'b00, 1, 1, 0, "add_pc"));
    vq.push_back(mk(2'b11, 6'b000000, 4'd15, 3, 2'b00, 0, 0, 0, "undef"));
    vq.push_back(mk(2'b00, 6'b000001, 4'd4,  4, 2'b10, 0, 1, 0, "ands"));
    vq.push_back(mk(2'b00, 6'b111000, 4'd5,  4, 2'b00, 0, 1, 0, "orr_imm"));
    vq.push_back(mk(2'b00, 6'b001101, 4'd6,  4, 2'b00, 0, 0, 0, "bad_cmd"));
    vq.push_back(mk(2'b01, 6'b000001, 4'd15, 5, 2'b00, 1, 1, 0, "ldr_pc"));
    vq.push_back(mk(2'b00, 6'b010101, 4'd15, 4, 2'b11, 0, 0, 0, "cmp_r15"));

    reset = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    rexp = model(2'b00, 6'd0, 4'd0, 0);
    rexp.next_pc = 0; rexp.ir_write = 0;
    #3 check_outs("reset_t0", rexp);
    @(posedge clk);
    @(negedge clk);
    check_outs("reset_held", rexp);
    reset = 1'b1;

    foreach (vq[i]) begin
      run_instr(vq[i].op, vq[i].funct, vq[i].rd, vq[i].name, lat, fw, p, r, m);
      check_int({vq[i].name, " latency"}, lat, vq[i].lat);
      check_int({vq[i].name, " flagw_exec"}, int'(fw), int'(vq[i].fw));
      check_int({vq[i].name, " pcs_cycles"}, p, vq[i].pcs_n);
      check_int({vq[i].name, " regw_cycles"}, r, vq[i].regw_n);
      check_int({vq[i].name, " memw_cycles"}, m, vq[i].memw_n);
    end

    // Reset asserted asynchronously in the middle of MEMADR of a load
    Op = 2'b01; Funct = 6'b000001; Rd = 4'd2;
    #1 check_outs("mid_fetch", model(2'b01, 6'b000001, 4'd2, 0));
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check_outs("mid_memadr", model(2'b01, 6'b000001, 4'd2, 2));
    #2 reset = 1'b0;
    #1;
    rexp = model(2'b01, 6'b000001, 4'd2, 0);
    rexp.next_pc = 0; rexp.ir_write = 0;
    check_outs("mid_reset_async", rexp);
    @(posedge clk); @(negedge clk);
    check_outs("mid_reset_held", rexp);
    reset = 1'b1;
    run_instr(2'b01, 6'b000001, 4'd2, "ldr_after_reset", lat, fw, p, r, m);
    check_int("ldr_after_reset latency", lat, 5);

    for (int n = 0; n < 150; n++) begin
      logic [1:0] rop;
      logic [5:0] rfn;
      logic [3:0] rrd;
      rop = 2'($urandom_range(0, 3));
      rfn = 6'($urandom);
      rrd = 4'($urandom);
      run_instr(rop, rfn, rrd, $sformatf("rand%0d", n), lat, fw, p, r, m);
      check_int($sformatf("rand%0d latency", n), lat, model_lat(rop, rfn));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unidad_control_multiciclo.md
Name: unidad_control_multiciclo

Overview:
Multicycle main controller for the ARM-subset processor. It decodes Op/Funct/Rd from the instruction register and sequences each instruction through a Moore FSM. It produces the datapath mux/enable controls and the unconditioned requests PCS, RegW, MemW and FlagW. Those requests go into the condition-gating unit, which qualifies them with Cond and the stored flags. The top level forms the PC enable as NextPC OR the gated PCSrc.

Parameters:
None. Encodings are fixed by the shared package.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
Op  in  2  instruction bits [27:26]
Funct  in  6  instruction bits [25:20]; [5]=I, [4:1]=cmd, [0]=S/L
Rd  in  4  instruction bits [15:12]
NextPC  out  1  unconditional PC write (fetch)
IRWrite  out  1  instruction register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  1  0=RD1, 1=PC
ALUSrcB  out  2  00=RD2/ExtImm-shifted, 01=ExtImm, 10=constant 4
ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
ImmSrc  out  2  equals Op
RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
FlagW  out  2  flag-write request; [1]=NZ, [0]=CV
PCS  out  1  PC-write request to the gating unit
RegW  out  1  register-write request
MemW  out  1  memory-write request

Behaviour:
- State register holds FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN. It loads asynchronously to FETCH when reset=0.
- While reset=0, NextPC, IRWrite, RegW, MemW, PCS and FlagW are forced to 0. Every other output takes its FETCH value.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=00 goes to EXECUTEI if Funct[5]=1, otherwise EXECUTER. Op=01 goes to MEMADR. Op=10 goes to BRANCH. Op=11 goes to UNKNOWN.
  - MEMADR: Funct[0]=1 goes to MEMREAD, otherwise MEMWRITE.
  - MEMREAD->MEMWB.
  - EXECUTER and EXECUTEI->ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH and UNKNOWN->FETCH.
- Instruction latency in cycles: data-processing 4, LDR 5, STR 4, B 3, undefined 3.
- Moore outputs. Unlisted signals are 0, and ALUOp is internal.
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1 unless NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: all requests 0.
- ALU decode:
  - ALUOp=0 gives ALUControl=ADD and FlagW=00.
  - ALUOp=1 decodes cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB with NoWrite=1). Any other cmd gives ADD with FlagW=00 and NoWrite=1.
  - FlagW[1]=S. FlagW[0]=S AND the command is ADD/SUB/CMP.
  - FlagW is non-zero only in EXECUTER and EXECUTEI; ALUWB writes the register only.
- PCS = (RegW AND Rd==15) OR Branch. It is combinational on the current state and Rd.
- Op, Funct and Rd change only at IRWrite, so decode-dependent outputs are stable from DECODE onward.
- Reset released mid-instruction restarts at FETCH; no partial instruction resumes.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum statetype_t;
  - localparams for ALUControl codes and ResultSrc/ALUSrcB codes;
  - the cmd constants CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP.
- One sub-module, decodificador_alu: combinational mapping of (ALUOp, Funct) to ALUControl, FlagW and NoWrite. The FSM, next-state logic and PCS/RegSrc/ImmSrc stay in the top.

Test Plan:
- ADD R1,R2,R3 (Op=00, Funct=001000, Rd=1): state sequence FETCH,DECODE,EXECUTER,ALUWB,FETCH. ALUControl=00 in EXECUTER, RegW=1 only in ALUWB, FlagW=00 throughout.
- SUBS R0,R0,#1 (Funct=100101): EXECUTEI gives ALUSrcB=01, ALUControl=01, FlagW=11. ALUWB gives RegW=1.
- CMP (Funct=010101, Rd=0): FlagW=11 in EXECUTER, RegW=0 in ALUWB, PCS=0.
- LDR then STR (Op=01, Funct[0]=1 then 0): LDR visits MEMADR,MEMREAD,MEMWB with AdrSrc=1 in MEMREAD and RegW=1/ResultSrc=01 in MEMWB. STR asserts MemW=1 for exactly one cycle.
- B (Op=10) and ADD PC,... (Rd=15): BRANCH gives PCS=1 for one cycle. For Rd=15, PCS=1 in ALUWB together with RegW=1. Op=11 goes DECODE->UNKNOWN->FETCH with no requests asserted.
- Pull reset low during MEMADR: state goes to FETCH immediately (asynchronously) with MemW/RegW/NextPC/IRWrite at 0. After release, the first edge gives IRWrite=1 and NextPC=1.
